// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and FSM encodings for the MEM-stage data-bus access controller.
package mem_access_ctrl_pkg;

    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;
    localparam logic ZeroBit = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int STALL_MEM_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_fsm.sv
// Request/handshake state machine: issues data_req, tracks addr_ok/data_ok, raises the MEM stall.
module mem_req_fsm
    import mem_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       need_acc,
    input  logic       stop,
    input  logic       data_addr_ok,
    input  logic       data_data_ok,
    output mem_state_t state,
    output logic       data_req,
    output logic       stallreq,
    output logic       capture
);

    mem_state_t state_reg;
    mem_state_t state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_req   = 1'b0;
        stallreq   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                data_req = need_acc;
                stallreq = need_acc;
                if (need_acc) begin
                    state_next = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Once raised, the request stays up until the bridge accepts it.
                data_req = 1'b1;
                stallreq = need_acc;
                if (data_addr_ok) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                capture  = data_data_ok;
                stallreq = need_acc & ~data_data_ok;
                if (data_data_ok) begin
                    state_next = (stop == Stop) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (stop == NoStop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Outputs must read 0 while reset is held, even though IDLE is input-driven.
        if (!reset) begin
            data_req = 1'b0;
            stallreq = 1'b0;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EXE/MEM load/store controls into a data-bus transaction and write-back value.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        stall,
    input  logic              i_write_mem,
    input  logic              i_write_regfile,
    input  logic              i_mem_to_regfile,
    input  logic [DATA_W-1:0] i_da,
    input  logic [DATA_W-1:0] i_db,
    input  logic [4:0]        i_rn,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok,
    output logic              stallreq_mem,
    output logic              o_write_regfile,
    output logic [4:0]        o_rn,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_unaligned
);

    logic              is_mem;
    logic              aligned;
    logic              need_acc;
    logic              capture;
    mem_state_t        state;
    logic [DATA_W-1:0] rdata_buf_reg;

    assign is_mem   = i_write_mem | i_mem_to_regfile;
    assign aligned  = (i_da[1:0] == 2'b00);
    assign need_acc = is_mem & aligned;

    mem_req_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .need_acc     (need_acc),
        .stop         (stall[STALL_MEM_BIT]),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .state        (state),
        .data_req     (data_req),
        .stallreq     (stallreq_mem),
        .capture      (capture)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_buf_reg <= '0;
        end else if (capture) begin
            rdata_buf_reg <= data_rdata;
        end
    end

    assign data_wr    = i_write_mem;
    assign data_addr  = {i_da[ADDR_W-1:2], 2'b00};
    assign data_wdata = i_db;

    assign o_unaligned     = is_mem & ~aligned;
    assign o_write_regfile = i_write_regfile & ~o_unaligned;
    assign o_rn            = i_rn;

    // Load result is forwarded in the data_ok cycle, then held from the buffer while stalled.
    always_comb begin
        o_wdata = i_da;
        if (i_mem_to_regfile) begin
            o_wdata = capture ? data_rdata : rdata_buf_reg;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: each task drives one scenario and checks outputs inline.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  stall;
    logic        i_write_mem;
    logic        i_write_regfile;
    logic        i_mem_to_regfile;
    logic [31:0] i_da;
    logic [31:0] i_db;
    logic [4:0]  i_rn;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        stallreq_mem;
    logic        o_write_regfile;
    logic [4:0]  o_rn;
    logic [31:0] o_wdata;
    logic        o_unaligned;

    int checks = 0;
    int failures = 0;

    mem_access_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .i_write_mem     (i_write_mem),
        .i_write_regfile (i_write_regfile),
        .i_mem_to_regfile(i_mem_to_regfile),
        .i_da            (i_da),
        .i_db            (i_db),
        .i_rn            (i_rn),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_rdata      (data_rdata),
        .data_data_ok    (data_data_ok),
        .stallreq_mem    (stallreq_mem),
        .o_write_regfile (o_write_regfile),
        .o_rn            (o_rn),
        .o_wdata         (o_wdata),
        .o_unaligned     (o_unaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    task automatic set_instr(input logic wm, input logic wr, input logic m2r,
                             input logic [31:0] da, input logic [31:0] db, input logic [4:0] rn);
        i_write_mem      = wm;
        i_write_regfile  = wr;
        i_mem_to_regfile = m2r;
        i_da             = da;
        i_db             = db;
        i_rn             = rn;
    endtask

    task automatic set_nop();
        set_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stall = 6'b0;
        bus_idle();
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 5'd3);
        #1;
        checks++;
        if (data_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_data_req: got %b want 0", data_req);
        end
        checks++;
        if (stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL reset_stallreq: got %b want 0", stallreq_mem);
        end
        checks++;
        if (dut.rdata_buf_reg !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata_buf: got %h want 0", dut.rdata_buf_reg);
        end
        $display("reset: data_req=%b stallreq_mem=%b", data_req, stallreq_mem);
        tick();
        tick();
        set_nop();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_1004, 32'h0, 5'd9);
        data_addr_ok = 1'b1;
        #1;
        checks++;
        if ({data_req, data_wr, stallreq_mem} !== 3'b101 || data_addr !== 32'h0000_1004) begin
            failures++;
            $display("FAIL load_issue: req/wr/stall=%b%b%b addr=%h want 101 addr=00001004",
                     data_req, data_wr, stallreq_mem, data_addr);
        end
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (data_req !== 1'b0 || stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL load_dataok_ctrl: req=%b stall=%b want 0 0", data_req, stallreq_mem);
        end
        checks++;
        if (o_wdata !== 32'hDEAD_BEEF || o_write_regfile !== 1'b1 || o_rn !== 5'd9) begin
            failures++;
            $display("FAIL load_result: wdata=%h wreg=%b rn=%0d want deadbeef 1 9",
                     o_wdata, o_write_regfile, o_rn);
        end
        $display("load: addr=1004 wdata=%h", o_wdata);
        tick();
        bus_idle();
        set_nop();
        #1;
        checks++;
        if (data_req !== 1'b0 || stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL load_after_idle: req=%b stall=%b want 0 0", data_req, stallreq_mem);
        end
    endtask

    task automatic test_store();
        int req_cycles = 0;
        set_instr(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h1234_5678, 5'd0);
        for (int c = 0; c < 4; c++) begin
            data_addr_ok = (c == 3);
            #1;
            if (data_req === 1'b1) req_cycles++;
            checks++;
            if (data_req !== 1'b1 || data_wr !== 1'b1 || data_addr !== 32'h0000_2000 ||
                data_wdata !== 32'h1234_5678 || stallreq_mem !== 1'b1) begin
                failures++;
                $display("FAIL store_req_c%0d: req=%b wr=%b addr=%h wdata=%h stall=%b want 1 1 00002000 12345678 1",
                         c, data_req, data_wr, data_addr, data_wdata, stallreq_mem);
            end
            tick();
        end
        data_addr_ok = 1'b0;
        #1;
        checks++;
        if (data_req !== 1'b0 || stallreq_mem !== 1'b1) begin
            failures++;
            $display("FAIL store_wait_data: req=%b stall=%b want 0 1", data_req, stallreq_mem);
        end
        tick();
        data_data_ok = 1'b1;
        #1;
        checks++;
        if (stallreq_mem !== 1'b0 || data_req !== 1'b0) begin
            failures++;
            $display("FAIL store_dataok: stall=%b req=%b want 0 0", stallreq_mem, data_req);
        end
        checks++;
        if (req_cycles != 4) begin
            failures++;
            $display("FAIL store_req_len: got %0d want 4", req_cycles);
        end
        $display("store: addr=2000 wdata=12345678 req_cycles=%0d", req_cycles);
        tick();
        bus_idle();
        set_nop();
    endtask

    task automatic test_load_held();
        stall = 6'b001111;
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h0, 5'd4);
        data_addr_ok = 1'b1;
        #1;
        checks++;
        if (data_req !== 1'b1) begin
            failures++;
            $display("FAIL held_issue: req=%b want 1", data_req);
        end
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        #1;
        checks++;
        if (o_wdata !== 32'hCAFE_F00D || stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL held_dataok: wdata=%h stall=%b want cafef00d 0", o_wdata, stallreq_mem);
        end
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) stall = 6'b0;
            #1;
            checks++;
            if (data_req !== 1'b0 || stallreq_mem !== 1'b0 || o_wdata !== 32'hCAFE_F00D ||
                dut.u_fsm.state !== 2'd3) begin
                failures++;
                $display("FAIL held_done_c%0d: req=%b stall=%b wdata=%h state=%0d want 0 0 cafef00d 3",
                         c, data_req, stallreq_mem, o_wdata, dut.u_fsm.state);
            end
            tick();
        end
        bus_idle();
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_3004, 32'h0, 5'd5);
        #1;
        checks++;
        if (dut.u_fsm.state !== 2'd0 || data_req !== 1'b1 || data_addr !== 32'h0000_3004) begin
            failures++;
            $display("FAIL held_release: state=%0d req=%b addr=%h want 0 1 00003004",
                     dut.u_fsm.state, data_req, data_addr);
        end
        $display("load_held: buffered=%h", dut.rdata_buf_reg);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BAD_0001;
        #1;
        checks++;
        if (o_wdata !== 32'h0BAD_0001) begin
            failures++;
            $display("FAIL held_next_load: wdata=%h want 0bad0001", o_wdata);
        end
        tick();
        bus_idle();
        set_nop();
    endtask

    task automatic test_nonmem();
        set_instr(1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'hFFFF_FFFF, 5'd7);
        #1;
        checks++;
        if (data_req !== 1'b0 || stallreq_mem !== 1'b0 || o_wdata !== 32'h55 ||
            o_rn !== 5'd7 || o_write_regfile !== 1'b1 || o_unaligned !== 1'b0) begin
            failures++;
            $display("FAIL nonmem: req=%b stall=%b wdata=%h rn=%0d wreg=%b unal=%b want 0 0 55 7 1 0",
                     data_req, stallreq_mem, o_wdata, o_rn, o_write_regfile, o_unaligned);
        end
        $display("nonmem: wdata=%h rn=%0d", o_wdata, o_rn);
        tick();
        set_nop();
    endtask

    task automatic test_unaligned();
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_1002, 32'h0, 5'd2);
        #1;
        checks++;
        if (o_unaligned !== 1'b1 || data_req !== 1'b0 || o_write_regfile !== 1'b0 ||
            stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL unaligned_load: unal=%b req=%b wreg=%b stall=%b want 1 0 0 0",
                     o_unaligned, data_req, o_write_regfile, stallreq_mem);
        end
        tick();
        set_instr(1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'hAAAA_5555, 5'd0);
        #1;
        checks++;
        if (o_unaligned !== 1'b1 || data_req !== 1'b0 || stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL unaligned_store: unal=%b req=%b stall=%b want 1 0 0",
                     o_unaligned, data_req, stallreq_mem);
        end
        $display("unaligned: load 1002 and store 2001 suppressed");
        tick();
        set_nop();
    endtask

    task automatic test_reset_in_data();
        set_instr(1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0, 5'd6);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        checks++;
        if (dut.u_fsm.state !== 2'd2 || stallreq_mem !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_data: state=%0d stall=%b want 2 1", dut.u_fsm.state, stallreq_mem);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (data_req !== 1'b0 || stallreq_mem !== 1'b0 || dut.u_fsm.state !== 2'd0) begin
            failures++;
            $display("FAIL rst_async: req=%b stall=%b state=%0d want 0 0 0",
                     data_req, stallreq_mem, dut.u_fsm.state);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        data_addr_ok = 1'b1;
        #1;
        checks++;
        if (data_req !== 1'b1 || data_addr !== 32'h0000_4000 || stallreq_mem !== 1'b1) begin
            failures++;
            $display("FAIL rst_reissue: req=%b addr=%h stall=%b want 1 00004000 1",
                     data_req, data_addr, stallreq_mem);
        end
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h4444_0000;
        #1;
        checks++;
        if (o_wdata !== 32'h4444_0000 || stallreq_mem !== 1'b0) begin
            failures++;
            $display("FAIL rst_reissue_done: wdata=%h stall=%b want 44440000 0", o_wdata, stallreq_mem);
        end
        $display("reset_in_data: reissued load wdata=%h", o_wdata);
        tick();
        bus_idle();
        set_nop();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        logic [31:0] vals  [2];
        addrs[0] = 32'h0000_5000; vals[0] = 32'hA5A5_0001;
        addrs[1] = 32'h0000_5008; vals[1] = 32'h5A5A_0002;
        for (int k = 0; k < 2; k++) begin
            set_instr(1'b0, 1'b1, 1'b1, addrs[k], 32'h0, 5'(10 + k));
            data_addr_ok = 1'b1;
            data_data_ok = 1'b0;
            #1;
            checks++;
            if (data_req !== 1'b1 || data_addr !== addrs[k]) begin
                failures++;
                $display("FAIL b2b_issue%0d: req=%b addr=%h want 1 %h", k, data_req, data_addr, addrs[k]);
            end
            tick();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
            data_rdata   = vals[k];
            #1;
            checks++;
            if (o_wdata !== vals[k] || stallreq_mem !== 1'b0) begin
                failures++;
                $display("FAIL b2b_data%0d: wdata=%h stall=%b want %h 0", k, o_wdata, stallreq_mem, vals[k]);
            end
            $display("back_to_back: load %0d addr=%h wdata=%h", k, addrs[k], o_wdata);
            tick();
        end
        bus_idle();
        set_nop();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_load_held();
        test_nonmem();
        test_unaligned();
        test_reset_in_data();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Turns the load/store control bits, address (da) and store data (db) into a req/addr_ok/data_ok data-bus transaction, raises a stall request while the access is outstanding, and presents the write-back value and destination register to the MEM/WB register.
- Sits between the EXE/MEM register, the data-side bus bridge, and the stall controller.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus data width (word accesses only)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  6  pipeline stall vector; stall[3]=1 (Stop) means the MEM-stage instruction is held
- i_write_mem  input  1  store instruction in MEM
- i_write_regfile  input  1  instruction writes the register file
- i_mem_to_regfile  input  1  load instruction (write-back value comes from memory)
- i_da  input  32  ALU result / memory address
- i_db  input  32  store data
- i_rn  input  5  destination register
- data_req  output  1  bus request
- data_wr  output  1  1 = write, 0 = read
- data_addr  output  32  word address; bits[1:0] forced to 0
- data_wdata  output  32  store data
- data_addr_ok  input  1  request accepted this cycle (data_req & data_addr_ok)
- data_rdata  input  32  read data, valid with data_data_ok
- data_data_ok  input  1  transaction complete; earliest one cycle after acceptance
- stallreq_mem  output  1  to stall controller
- o_write_regfile  output  1  to MEM/WB
- o_rn  output  5  to MEM/WB
- o_wdata  output  32  write-back value to MEM/WB
- o_unaligned  output  1  i_da[1:0]!=0 on a load/store; access suppressed

Behaviour:
- need_acc = (i_write_mem | i_mem_to_regfile) & (i_da[1:0]==0). Unaligned load/store: no bus access, o_unaligned=1, o_write_regfile forced to 0.
- FSM states: IDLE, ADDR (req asserted, awaiting addr_ok), DATA (accepted, awaiting data_ok), DONE (result buffered, instruction still held).
- IDLE: data_req = need_acc (combinational). If need_acc & data_addr_ok -> DATA. If need_acc & !data_addr_ok -> ADDR.
- ADDR: data_req=1 with stable data_addr, data_wr and data_wdata; on data_addr_ok -> DATA. The request is never withdrawn once raised, except by reset.
- DATA: data_req=0. On data_data_ok, capture data_rdata into rdata_buf. Next state is DONE if stall[3]=Stop, otherwise IDLE.
- DONE: no new request. Return to IDLE on the first cycle with stall[3]=NoStop. This blocks re-issue while a later stage holds the pipeline.
- stallreq_mem = need_acc & !(state==DATA & data_data_ok) & state!=DONE. It drops in the data_ok cycle so the instruction can advance on the next edge.
- o_wdata: for a load, data_rdata in the data_ok cycle, else rdata_buf; for any other instruction, i_da.
- o_rn = i_rn. o_write_regfile = i_write_regfile & !o_unaligned.
- A non-memory instruction in IDLE passes straight through with zero added latency.
- Latency: load/store takes at least 2 cycles (addr_ok in cycle 0, data_ok in cycle 1); stallreq_mem is high in cycle 0 only.
- Reset (async, any state): state=IDLE, rdata_buf=0. Every output that does not depend on inputs is 0: data_req=0, stallreq_mem=0. The bus bridge must discard any in-flight response after reset.
- Simultaneous events: data_data_ok with stall[3]=NoStop goes directly to IDLE. addr_ok seen in the same cycle as an IDLE request counts as acceptance.

Decomposition:
- Shared package/defines: Stop/NoStop, ZeroWord, ZeroBit, and the FSM state encodings (2-bit: IDLE=0, ADDR=1, DATA=2, DONE=3).
- Optional sub-module mem_req_fsm holding the state register and handshake logic. The datapath mux and rdata_buf stay in the top level.

Test Plan:
- Load, i_da=0x0000_1004, addr_ok same cycle, data_ok next cycle with rdata=0xDEAD_BEEF:
  - data_req=1/data_wr=0/data_addr=0x1004 for 1 cycle; stallreq_mem=1 for 1 cycle.
  - o_wdata=0xDEAD_BEEF; o_write_regfile=1.
- Store, i_da=0x2000, i_db=0x1234_5678, addr_ok delayed 3 cycles:
  - data_req held 4 cycles with stable addr/wdata; data_wr=1.
  - stallreq_mem stays high until the data_ok cycle.
- Load completes (data_ok) while stall[3]=1 for 2 more cycles:
  - state DONE; no second data_req; o_wdata holds the buffered value; IDLE once stall[3]=0.
- Non-memory instruction, i_da=0x55, i_rn=7, i_write_regfile=1:
  - data_req=0, stallreq_mem=0, o_wdata=0x55, o_rn=7 in the same cycle.
- Load with i_da=0x1002:
  - o_unaligned=1, data_req=0, o_write_regfile=0, stallreq_mem=0.
- reset=0 asserted while in DATA:
  - data_req and stallreq_mem go to 0 asynchronously; state=IDLE after reset releases; the next load issues normally.
